// File: rtl/td4_prog_sequencer.sv
// td4_prog_sequencer: TD4 program store plus run/step/halt clock-enable controller.
// Define TD4_SEQ_BREAKPOINT_EN to add the bp_valid/bp_addr run breakpoint.
module td4_prog_sequencer #(
    parameter int DIV_W   = 8,
    parameter int PROG_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic               wr_valid,
    input  logic [7:0]         wr_data,
    input  logic [DIV_W-1:0]   run_div,
    input  logic [PROG_AW-1:0] cpu_pc,
`ifdef TD4_SEQ_BREAKPOINT_EN
    input  logic               bp_valid,
    input  logic [PROG_AW-1:0] bp_addr,
`endif
    output logic [3:0]         cpu_opcode,
    output logic [3:0]         cpu_imm,
    output logic               cpu_ce,
    output logic [2:0]         state,
    output logic [PROG_AW-1:0] load_addr,
    output logic               halted
);

    localparam int DEPTH = 1 << PROG_AW;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam logic [DIV_W-1:0]   CNT_ONE  = 1;
    localparam logic [PROG_AW-1:0] ADDR_ONE = 1;
    localparam logic [PROG_AW-1:0] ADDR_TOP = '1;

    logic [7:0]         mem_q [DEPTH];
    logic [2:0]         state_q, state_d;
    logic [PROG_AW-1:0] load_addr_q, load_addr_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               mem_we;

    logic [7:0] cur_byte;
    logic       stop_cmd;
    logic       halt_hit;
    logic       div_hit;
    logic       pulse_due;
    logic       bp_hit;
    logic       rearm_blocked;

    assign cur_byte   = mem_q[cpu_pc];
    assign cpu_opcode = cur_byte[3:0];
    assign cpu_imm    = cur_byte[7:4];

    // Jump-to-self: JMP imm with imm equal to the address it sits at.
    assign halt_hit = (cpu_opcode == 4'hF) && (cpu_imm == cpu_pc);
    assign stop_cmd = cmd_valid && (cmd == CMD_STOP);
    assign div_hit  = (cnt_q == run_div);

    assign pulse_due = ((state_q == S_RUN) && div_hit)
                     || (state_q == S_STEP);

`ifdef TD4_SEQ_BREAKPOINT_EN
    assign bp_hit = (state_q == S_RUN) && bp_valid
                  && (cpu_pc == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    assign cpu_ce = pulse_due && !stop_cmd
                  && !halt_hit && !bp_hit;

    // Leaving HALT on RUN/STEP is pointless while the CPU still sits on the idiom.
    assign rearm_blocked = (state_q == S_HALT) && halt_hit;

    assign state     = state_q;
    assign load_addr = load_addr_q;
    assign halted    = (state_q == S_HALT);

    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        cnt_d       = cnt_q;
        mem_we      = 1'b0;
        if (stop_cmd) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (cmd_valid && (cmd == CMD_LOAD)) begin
                        state_d     = S_LOAD;
                        load_addr_d = '0;
                    end else if (cmd_valid && !rearm_blocked) begin
                        if (cmd == CMD_RUN) begin
                            state_d = S_RUN;
                            cnt_d   = '0;
                        end else if (cmd == CMD_STEP) begin
                            state_d = S_STEP;
                        end
                    end
                end
                S_LOAD: begin
                    if (wr_valid) begin
                        mem_we      = 1'b1;
                        load_addr_d = load_addr_q + ADDR_ONE;
                        if (load_addr_q == ADDR_TOP) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_RUN: begin
                    if (div_hit) begin
                        cnt_d = '0;
                        if (halt_hit) begin
                            state_d = S_HALT;
                        end else if (bp_hit) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STEP: begin
                    state_d = halt_hit ? S_HALT : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            load_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[load_addr_q] <= wr_data;
        end
    end

endmodule
